bram_wr_fsm: RTL and testbench



---
 rtl/bram_wr_fsm_if.sv | 26 ++
 rtl/clk_rstn_if.sv | 8 +
 rtl/bram_wr_fsm.sv | 140 ++++++++++++++
 tb/tb_bram_wr_fsm.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_wr_fsm_if.sv
// Sample stream handshake plus BRAM write port and reader kick for bram_wr_fsm.
interface bram_wr_fsm_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              enable_i;
   logic              s_valid_i;
   logic [DATA_W-1:0] s_data_i;
   logic              s_ready_o;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [DATA_W-1:0] wr_data_o;
   logic              control_o;
   logic              busy_o;

   modport master (
      output enable_i, output s_valid_i, output s_data_i,
      input  s_ready_o, input wr_en_o, input wr_addr_o, input wr_data_o,
      input  control_o, input busy_o
   );
   modport slave (
      input  enable_i, input s_valid_i, input s_data_i,
      output s_ready_o, output wr_en_o, output wr_addr_o, output wr_data_o,
      output control_o, output busy_o
   );
endinterface : bram_wr_fsm_if

// File: rtl/clk_rstn_if.sv
// Clock and asynchronous active-low reset bundle shared by the BRAM producer and reader.
interface clk_rstn_if;
   logic clk_i;
   logic rstn_i;

   modport master (output clk_i, output rstn_i);
   modport slave  (input  clk_i, input  rstn_i);
endinterface : clk_rstn_if

// File: rtl/bram_wr_fsm.sv
// Frame writer: stores DEPTH samples at BRAM addresses 0..DEPTH-1, kicks the reader, then holds off.
// Optional FRAME_CNT_EN adds a 16-bit wrapping frame counter output frame_cnt_o.
module bram_wr_fsm #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 3,
   parameter int HOLD_CYCLES = 48
) (
   clk_rstn_if.slave    cr,
   bram_wr_fsm_if.slave bus
`ifdef FRAME_CNT_EN
   ,
   output logic [15:0]  frame_cnt_o
`endif
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FILL = 3'd1,
      ST_LAST = 3'd2,
      ST_KICK = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   idx_r;
   logic [HOLD_W-1:0]   hold_cnt_r;
   logic                s_ready_r;
   logic                wr_en_r;
   logic [ADDR_W-1:0]   wr_addr_r;
   logic [DATA_W-1:0]   wr_data_r;
   logic                control_r;
   logic                busy_r;

   // Frame sequencer; ready/busy are registered alongside the state so they decode it without
   // any combinational path from the stream inputs.
   always_ff @(posedge cr.clk_i or negedge cr.rstn_i) begin
      if (!cr.rstn_i) begin
         state_r    <= ST_IDLE;
         idx_r      <= {ADDR_W{1'b0}};
         hold_cnt_r <= {HOLD_W{1'b0}};
         s_ready_r  <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {ADDR_W{1'b0}};
         wr_data_r  <= {DATA_W{1'b0}};
         control_r  <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         wr_en_r   <= 1'b0;
         control_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               idx_r <= {ADDR_W{1'b0}};
               if (bus.enable_i) begin
                  state_r   <= ST_FILL;
                  s_ready_r <= 1'b1;
                  busy_r    <= 1'b1;
               end else begin
                  state_r   <= ST_IDLE;
                  s_ready_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            end
            ST_FILL: begin
               if (bus.s_valid_i && s_ready_r) begin
                  wr_en_r   <= 1'b1;
                  wr_addr_r <= idx_r;
                  wr_data_r <= bus.s_data_i;
                  // Index wraps to zero naturally after the last word of the frame.
                  idx_r     <= idx_r + ADDR_W'(1);
                  if (idx_r == ADDR_W'(DEPTH - 1)) begin
                     state_r   <= ST_LAST;
                     s_ready_r <= 1'b0;
                  end else begin
                     state_r   <= ST_FILL;
                  end
               end else begin
                  state_r <= ST_FILL;
               end
            end
            ST_LAST: begin
               state_r   <= ST_KICK;
               control_r <= 1'b1;
            end
            ST_KICK: begin
               state_r    <= ST_HOLD;
               hold_cnt_r <= {HOLD_W{1'b0}};
            end
            ST_HOLD: begin
               if (hold_cnt_r == HOLD_W'(HOLD_CYCLES - 1)) begin
                  hold_cnt_r <= {HOLD_W{1'b0}};
                  if (bus.enable_i) begin
                     state_r   <= ST_FILL;
                     s_ready_r <= 1'b1;
                  end else begin
                     state_r   <= ST_IDLE;
                     busy_r    <= 1'b0;
                  end
               end else begin
                  hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               idx_r      <= {ADDR_W{1'b0}};
               hold_cnt_r <= {HOLD_W{1'b0}};
               s_ready_r  <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

`ifdef FRAME_CNT_EN
   logic [15:0] frame_cnt_r;

   // Completed-frame counter, stepping once per reader kick.
   always_ff @(posedge cr.clk_i or negedge cr.rstn_i) begin
      if (!cr.rstn_i) begin
         frame_cnt_r <= 16'd0;
      end else if (state_r == ST_KICK) begin
         frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign frame_cnt_o = frame_cnt_r;
`endif

   assign bus.s_ready_o = s_ready_r;
   assign bus.wr_en_o   = wr_en_r;
   assign bus.wr_addr_o = wr_addr_r;
   assign bus.wr_data_o = wr_data_r;
   assign bus.control_o = control_r;
   assign bus.busy_o    = busy_r;

endmodule : bram_wr_fsm

// File: tb/tb_bram_wr_fsm.sv
// Directed self-checking bench for bram_wr_fsm at default parameters (DEPTH 8, HOLD_CYCLES 48).
module tb_bram_wr_fsm;

   clk_rstn_if cr ();
   bram_wr_fsm_if #(.DATA_W(16), .ADDR_W(3)) bus ();

`ifdef FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int checks = 0;
   int errors = 0;

   bram_wr_fsm #(
      .DATA_W(16), .DEPTH(8), .ADDR_W(3), .HOLD_CYCLES(48)
   ) dut (
      .cr (cr),
      .bus(bus)
`ifdef FRAME_CNT_EN
      ,
      .frame_cnt_o(frame_cnt)
`endif
   );

   initial begin
      cr.clk_i = 1'b0;
      forever #5 cr.clk_i = ~cr.clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic apply_reset();
      bus.enable_i  = 1'b0;
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = 16'h0000;
      @(negedge cr.clk_i);
      cr.rstn_i = 1'b0;
      @(negedge cr.clk_i);
      @(negedge cr.clk_i);
      cr.rstn_i = 1'b1;
   endtask

   task automatic test_reset();
      cr.rstn_i = 1'b0;
      bus.enable_i = 1'b0; bus.s_valid_i = 1'b0; bus.s_data_i = 16'h0000;
      @(negedge cr.clk_i);
      checks++;
      if ({bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, bus.control_o, bus.busy_o, bus.s_ready_o} !== 22'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b/%0d/%h/%b/%b/%b, expected all zero",
                  bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, bus.control_o, bus.busy_o, bus.s_ready_o);
      end
      cr.rstn_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge cr.clk_i);
         checks++;
         if ({bus.busy_o, bus.s_ready_o, bus.wr_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_enable: got busy/ready/wr_en %b%b%b, expected 000",
                     bus.busy_o, bus.s_ready_o, bus.wr_en_o);
         end
      end
   endtask

   task automatic test_full_frame();
      int sum, low_cnt, ctrl_cnt, ctrl_at, hold_wr;
      bit done;
      apply_reset();
      bus.enable_i = 1'b1; bus.s_valid_i = 1'b1; bus.s_data_i = 16'h0001;
      @(negedge cr.clk_i);
      checks++;
      if ({bus.s_ready_o, bus.busy_o, bus.wr_en_o} !== 3'b110) begin
         errors++;
         $display("FAIL fill_entry: got ready/busy/wr_en %b%b%b, expected 110",
                  bus.s_ready_o, bus.busy_o, bus.wr_en_o);
      end
      sum = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge cr.clk_i);
         checks++;
         if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 3'(k) || bus.wr_data_o !== 16'(k + 1)) begin
            errors++;
            $display("FAIL frame_write%0d: got en %b addr %0d data %h, expected en 1 addr %0d data %h",
                     k, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, k, 16'(k + 1));
         end
         sum += int'(bus.wr_data_o);
         bus.s_data_i = 16'(k + 2);
      end
      low_cnt = 0; ctrl_cnt = 0; ctrl_at = -1; hold_wr = 0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (bus.s_ready_o) begin
            done = 1'b1;
         end else begin
            low_cnt++;
            if (bus.control_o) begin
               ctrl_cnt++;
               if (ctrl_at < 0) ctrl_at = i;
            end
            if (i > 0 && bus.wr_en_o) hold_wr++;
            @(negedge cr.clk_i);
         end
      end
      checks++;
      if (!done || low_cnt != 50) begin
         errors++;
         $display("FAIL ready_low_cycles: got %0d (done %b), expected 50", low_cnt, done);
      end
      checks++;
      if (ctrl_cnt != 1 || ctrl_at != 1) begin
         errors++;
         $display("FAIL control_pulse: got %0d pulses first at %0d, expected 1 pulse at 1", ctrl_cnt, ctrl_at);
      end
      checks++;
      if (hold_wr != 0) begin
         errors++;
         $display("FAIL writes_after_last: got %0d, expected 0", hold_wr);
      end
      checks++;
      if ((sum >> 3) != 4) begin
         errors++;
         $display("FAIL frame_average: got %0d, expected 4", sum >> 3);
      end
      bus.enable_i = 1'b0; bus.s_valid_i = 1'b0;
   endtask

   task automatic test_valid_gaps();
      apply_reset();
      bus.enable_i = 1'b1; bus.s_valid_i = 1'b0;
      @(negedge cr.clk_i);
      bus.s_valid_i = 1'b1; bus.s_data_i = 16'h0010;
      @(negedge cr.clk_i);
      checks++;
      if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 3'd0 || bus.wr_data_o !== 16'h0010) begin
         errors++;
         $display("FAIL gap_beat0: got en %b addr %0d data %h, expected 1 0 0010",
                  bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
      end
      bus.s_valid_i = 1'b0; bus.s_data_i = 16'h0BAD;
      @(negedge cr.clk_i);
      checks++;
      if (bus.wr_en_o !== 1'b0 || bus.wr_addr_o !== 3'd0 || bus.wr_data_o !== 16'h0010) begin
         errors++;
         $display("FAIL gap_idle0: got en %b addr %0d data %h, expected 0 0 0010",
                  bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
      end
      bus.s_valid_i = 1'b1; bus.s_data_i = 16'h0020;
      @(negedge cr.clk_i);
      checks++;
      if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 3'd1 || bus.wr_data_o !== 16'h0020) begin
         errors++;
         $display("FAIL gap_beat1: got en %b addr %0d data %h, expected 1 1 0020",
                  bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
      end
      bus.s_valid_i = 1'b0;
      @(negedge cr.clk_i);
      checks++;
      if (bus.wr_en_o !== 1'b0 || bus.wr_addr_o !== 3'd1) begin
         errors++;
         $display("FAIL gap_idle1: got en %b addr %0d, expected 0 1", bus.wr_en_o, bus.wr_addr_o);
      end
      bus.enable_i = 1'b0;
   endtask

   task automatic test_hold_backpressure();
      int hold_wr;
      bit done;
      apply_reset();
      bus.enable_i = 1'b1; bus.s_valid_i = 1'b1; bus.s_data_i = 16'h0001;
      @(negedge cr.clk_i);
      for (int k = 0; k < 8; k++) begin
         @(negedge cr.clk_i);
         bus.s_data_i = (k == 7) ? 16'hFFFF : 16'(k + 2);
      end
      hold_wr = 0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (bus.s_ready_o) begin
            done = 1'b1;
         end else begin
            if (i > 0 && bus.wr_en_o) hold_wr++;
            @(negedge cr.clk_i);
         end
      end
      checks++;
      if (!done || hold_wr != 0 || bus.wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL hold_ignores_valid: got %0d writes (done %b, en %b), expected 0 writes",
                  hold_wr, done, bus.wr_en_o);
      end
      @(negedge cr.clk_i);
      checks++;
      if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 3'd0 || bus.wr_data_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL refill_first: got en %b addr %0d data %h, expected 1 0 FFFF",
                  bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
      end
      bus.enable_i = 1'b0; bus.s_valid_i = 1'b0;
   endtask

   task automatic test_enable_drop();
      int ctrl_cnt, idle_at;
      apply_reset();
      bus.enable_i = 1'b1; bus.s_valid_i = 1'b1; bus.s_data_i = 16'h0100;
      @(negedge cr.clk_i);
      for (int k = 0; k < 8; k++) begin
         @(negedge cr.clk_i);
         checks++;
         if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 3'(k) || bus.wr_data_o !== 16'(16'h0100 + k)) begin
            errors++;
            $display("FAIL drop_write%0d: got en %b addr %0d data %h, expected 1 %0d %h",
                     k, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, k, 16'(16'h0100 + k));
         end
         if (k == 2) bus.enable_i = 1'b0;
         bus.s_data_i = 16'(16'h0101 + k);
      end
      ctrl_cnt = 0; idle_at = -1;
      for (int i = 0; i < 100 && idle_at < 0; i++) begin
         if (!bus.busy_o) begin
            idle_at = i;
         end else begin
            if (bus.control_o) ctrl_cnt++;
            @(negedge cr.clk_i);
         end
      end
      checks++;
      if (ctrl_cnt != 1 || idle_at != 50) begin
         errors++;
         $display("FAIL drop_completion: got %0d pulses idle at %0d, expected 1 pulse idle at 50",
                  ctrl_cnt, idle_at);
      end
      @(negedge cr.clk_i);
      checks++;
      if ({bus.busy_o, bus.s_ready_o, bus.wr_en_o} !== 3'b000) begin
         errors++;
         $display("FAIL drop_stays_idle: got busy/ready/wr_en %b%b%b, expected 000",
                  bus.busy_o, bus.s_ready_o, bus.wr_en_o);
      end
      bus.s_valid_i = 1'b0;
   endtask

   task automatic test_midframe_reset();
      int bad_ctrl;
      apply_reset();
      bus.enable_i = 1'b1; bus.s_valid_i = 1'b1; bus.s_data_i = 16'h0020;
      @(negedge cr.clk_i);
      for (int k = 0; k < 5; k++) begin
         @(negedge cr.clk_i);
         bus.s_data_i = 16'(16'h0021 + k);
      end
      checks++;
      if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 3'd4) begin
         errors++;
         $display("FAIL pre_reset_write: got en %b addr %0d, expected 1 4", bus.wr_en_o, bus.wr_addr_o);
      end
      cr.rstn_i = 1'b0;
      #1;
      checks++;
      if ({bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, bus.control_o, bus.busy_o, bus.s_ready_o} !== 22'd0) begin
         errors++;
         $display("FAIL async_reset: got %b/%0d/%h/%b/%b/%b, expected all zero",
                  bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, bus.control_o, bus.busy_o, bus.s_ready_o);
      end
      bad_ctrl = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge cr.clk_i);
         if (bus.control_o) bad_ctrl++;
      end
      bus.s_data_i = 16'h0A5A;
      cr.rstn_i = 1'b1;
      @(negedge cr.clk_i);
      if (bus.control_o) bad_ctrl++;
      @(negedge cr.clk_i);
      checks++;
      if (bad_ctrl != 0) begin
         errors++;
         $display("FAIL reset_no_kick: got %0d control cycles, expected 0", bad_ctrl);
      end
      checks++;
      if (bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== 3'd0 || bus.wr_data_o !== 16'h0A5A) begin
         errors++;
         $display("FAIL post_reset_write: got en %b addr %0d data %h, expected 1 0 0A5A",
                  bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
      end
      bus.enable_i = 1'b0; bus.s_valid_i = 1'b0;
   endtask

`ifdef FRAME_CNT_EN
   task automatic test_frame_cnt();
      bit found;
      apply_reset();
      checks++;
      if (frame_cnt !== 16'd0) begin
         errors++;
         $display("FAIL frame_cnt_reset: got %0d, expected 0", frame_cnt);
      end
      bus.enable_i = 1'b1; bus.s_valid_i = 1'b1; bus.s_data_i = 16'h0007;
      for (int f = 1; f <= 3; f++) begin
         found = 1'b0;
         for (int i = 0; i < 200 && !found; i++) begin
            @(negedge cr.clk_i);
            if (bus.control_o) found = 1'b1;
         end
         checks++;
         if (!found || frame_cnt !== 16'(f - 1)) begin
            errors++;
            $display("FAIL frame_cnt_kick%0d: got %0d (found %b), expected %0d", f, frame_cnt, found, f - 1);
         end
         @(negedge cr.clk_i);
         checks++;
         if (frame_cnt !== 16'(f)) begin
            errors++;
            $display("FAIL frame_cnt_step%0d: got %0d, expected %0d", f, frame_cnt, f);
         end
      end
      bus.enable_i = 1'b0; bus.s_valid_i = 1'b0;
   endtask
`endif

   initial begin
      cr.rstn_i     = 1'b0;
      bus.enable_i  = 1'b0;
      bus.s_valid_i = 1'b0;
      bus.s_data_i  = 16'h0000;
      test_reset();
      test_full_frame();
      test_valid_gaps();
      test_hold_backpressure();
      test_enable_drop();
      test_midframe_reset();
`ifdef FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bram_wr_fsm
